ctrl_sequencer: RTL and testbench

//  Multi-cycle control unit directly upstream of the regfile/ALU/RAM datapath. Fetches 32-bit instruction words

---
 rtl/ctrl_sequencer_pkg.sv | 61 ++++++
 rtl/ctrl_sequencer_if.sv | 40 ++++
 rtl/ctrl_sequencer_instr_decoder.sv | 30 +++
 rtl/ctrl_sequencer.sv | 163 ++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ctrl_sequencer_pkg.sv
// Shared types and constants for the control sequencer.
//   op_e        : 3-bit instruction opcode
//   state_e     : sequencer FSM state
//   ctrl_word_t : decoded control word registered by the sequencer in DECODE
// Instruction word layout:
//   [31:29] op, [28:24] functionsel, [23:19] writeReg, [18:14] readA, [13:9] readB,
//   [8:0] imm9. Bit 9 doubles as ALU carry-in; bits [27:24] are the branch flag mask.
package ctrl_seq_pkg;

  localparam int unsigned SIGNAL_W  = 4;
  localparam int unsigned SEL_W     = 5;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned IMM_W     = 9;
  localparam int unsigned OP_LSB    = 29;
  localparam int unsigned FSEL_LSB  = 24;
  localparam int unsigned WREG_LSB  = 19;
  localparam int unsigned RA_LSB    = 14;
  localparam int unsigned RB_LSB    = 9;
  localparam int unsigned IMM_LSB   = 0;
  localparam int unsigned MASK_LSB  = 24;
  localparam int unsigned CARRY_BIT = 9;

  typedef enum logic [OP_W-1:0] {
    OpAlu   = 3'b000,
    OpAlui  = 3'b001,
    OpLoad  = 3'b010,
    OpStore = 3'b011,
    OpBr    = 3'b100,
    OpJmp   = 3'b101,
    OpNop   = 3'b110,
    OpHalt  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  typedef struct packed {
    op_e                 op;
    logic [SEL_W-1:0]    fsel;
    logic [SEL_W-1:0]    wreg;
    logic [SEL_W-1:0]    read_a;
    logic [SEL_W-1:0]    read_b;
    logic                carry;
    logic                mux_sel;
    logic                wb_sel;
    logic [SIGNAL_W-1:0] mask;
    logic [63:0]         imm;
  } ctrl_word_t;

  function automatic logic [63:0] sext_imm9(input logic [IMM_W-1:0] imm);
    return {{(64 - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Instruction-fetch and datapath-control bundle of the control sequencer.
//   Fetch    : instr_req, pc (sequencer -> imem); instr_in, instr_valid (imem -> sequencer)
//   Datapath : readA, readB, writeReg, functionsel, ALUcarry, muxSelect, imm_out, wb_sel,
//              write, RAMwrite (sequencer -> datapath); signalBits (ALU -> sequencer)
// master = sequencer side, slave = memory/datapath side.
interface ctrl_sequencer_if
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned PC_W = 8
);

  logic                instr_req;
  logic [PC_W-1:0]     pc;
  logic [31:0]         instr_in;
  logic                instr_valid;
  logic [SIGNAL_W-1:0] signalBits;
  logic [SEL_W-1:0]    readA;
  logic [SEL_W-1:0]    readB;
  logic [SEL_W-1:0]    writeReg;
  logic [SEL_W-1:0]    functionsel;
  logic                ALUcarry;
  logic                muxSelect;
  logic [63:0]         imm_out;
  logic                wb_sel;
  logic                write;
  logic                RAMwrite;

  modport master (
    output instr_req, pc, readA, readB, writeReg, functionsel, ALUcarry, muxSelect,
           imm_out, wb_sel, write, RAMwrite,
    input  instr_in, instr_valid, signalBits
  );

  modport slave (
    input  instr_req, pc, readA, readB, writeReg, functionsel, ALUcarry, muxSelect,
           imm_out, wb_sel, write, RAMwrite,
    output instr_in, instr_valid, signalBits
  );

endinterface

// File: rtl/ctrl_sequencer_instr_decoder.sv
// Combinational instruction decoder: instruction register -> control word.
//   ir_i : latched 32-bit instruction word
//   cw_o : decoded control word (selects, ALU function, operand mux, imm, writeback source)
module instr_decoder
  import ctrl_seq_pkg::*;
(
  input  logic [31:0] ir_i,
  output ctrl_word_t  cw_o
);

  op_e op;

  assign op = op_e'(ir_i[OP_LSB +: OP_W]);

  always_comb begin
    cw_o         = '0;
    cw_o.op      = op;
    cw_o.fsel    = ir_i[FSEL_LSB +: SEL_W];
    cw_o.wreg    = ir_i[WREG_LSB +: SEL_W];
    cw_o.read_a  = ir_i[RA_LSB +: SEL_W];
    cw_o.read_b  = ir_i[RB_LSB +: SEL_W];
    cw_o.carry   = ir_i[CARRY_BIT];
    cw_o.mask    = ir_i[MASK_LSB +: SIGNAL_W];
    cw_o.imm     = sext_imm9(ir_i[IMM_LSB +: IMM_W]);
    // Loads and stores form their RAM address as base register + imm.
    cw_o.mux_sel = (op == OpAlui) || (op == OpLoad) || (op == OpStore);
    cw_o.wb_sel  = (op == OpLoad);
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: fetches, decodes and sequences instructions for the
// regfile/ALU/RAM datapath.
//   clk, rst : clock, asynchronous active-low reset
//   start    : leave IDLE/HALT and fetch at the current pc
//   bus      : fetch port and datapath controls (ctrl_sequencer_if.master)
//   busy     : 1 in every state except IDLE and HALT
//   halted   : 1 in HALT
//   instret  : retired-instruction counter, present only with SEQ_PERF_CNT_EN defined
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  ctrl_sequencer_if.master   bus,
  output logic               busy,
  output logic               halted
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        instret
`endif
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  ctrl_word_t      cw, cw_q;
  logic            load_cw;
  logic            instr_req_q;
  logic            write_q;
  logic            ramwrite_q;
  logic            busy_q;
  logic            halted_q;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_rel;

  instr_decoder u_decoder (
    .ir_i (ir_q),
    .cw_o (cw)
  );

  assign pc_inc = pc_q + PC_W'(1);
  assign pc_rel = pc_q + cw_q.imm[PC_W-1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    load_cw = 1'b0;
    unique case (state_q)
      StIdle, StHalt: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (instr_req_q && bus.instr_valid) begin
          ir_d    = bus.instr_in;
          state_d = StDecode;
        end
      end
      StDecode: begin
        load_cw = 1'b1;
        state_d = StExec;
      end
      StExec: begin
        unique case (cw_q.op)
          OpAlu, OpAlui:   state_d = StWb;
          OpLoad, OpStore: state_d = StMem;
          OpBr: begin
            pc_d    = ((bus.signalBits & cw_q.mask) != '0) ? pc_rel : pc_inc;
            state_d = StFetch;
          end
          OpJmp: begin
            pc_d    = pc_rel;
            state_d = StFetch;
          end
          OpNop: begin
            pc_d    = pc_inc;
            state_d = StFetch;
          end
          OpHalt: begin
            pc_d    = pc_inc;
            state_d = StHalt;
          end
          default: state_d = StIdle;
        endcase
      end
      StMem: begin
        if (cw_q.op == OpLoad) begin
          state_d = StWb;
        end else begin
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
      StWb: begin
        pc_d    = pc_inc;
        state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to;
  // the async reset clears any in-flight write/RAMwrite pulse immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pc_q        <= PC_W'(RESET_PC);
      ir_q        <= '0;
      cw_q        <= '0;
      instr_req_q <= 1'b0;
      write_q     <= 1'b0;
      ramwrite_q  <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      if (load_cw) cw_q <= cw;
      instr_req_q <= (state_d == StFetch);
      write_q     <= (state_d == StWb);
      ramwrite_q  <= (state_d == StMem) && (cw_q.op == OpStore);
      busy_q      <= !((state_d == StIdle) || (state_d == StHalt));
      halted_q    <= (state_d == StHalt);
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] instret_q;

  // An instruction retires when its last state hands over to FETCH, or when HALT is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= '0;
    end else if (((state_q == StExec) || (state_q == StMem) || (state_q == StWb)) &&
                 ((state_d == StFetch) || (state_d == StHalt))) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`endif

  assign bus.instr_req   = instr_req_q;
  assign bus.pc          = pc_q;
  assign bus.readA       = cw_q.read_a;
  assign bus.readB       = cw_q.read_b;
  assign bus.writeReg    = cw_q.wreg;
  assign bus.functionsel = cw_q.fsel;
  assign bus.ALUcarry    = cw_q.carry;
  assign bus.muxSelect   = cw_q.mux_sel;
  assign bus.imm_out     = cw_q.imm;
  assign bus.wb_sel      = cw_q.wb_sel;
  assign bus.write       = write_q;
  assign bus.RAMwrite    = ramwrite_q;
  assign busy            = busy_q;
  assign halted          = halted_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer.
module tb_ctrl_sequencer;
  import ctrl_seq_pkg::*;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic halted;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] instret;
`endif

  int checks = 0;
  int errors = 0;

  ctrl_sequencer_if #(.PC_W(8)) bus ();

  ctrl_sequencer #(
    .PC_W     (8),
    .RESET_PC (0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus.master),
    .busy    (busy),
    .halted  (halted)
`ifdef SEQ_PERF_CNT_EN
    ,
    .instret (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] fsel,
                                      input logic [4:0] wr, input logic [4:0] ra,
                                      input logic [4:0] rb, input logic [8:0] imm);
    return {op, fsel, wr, ra, rb, imm};
  endfunction

  // Waits (bounded) for instr_req, checks pc, presents the word for one cycle.
  // Returns at the negedge of the DECODE cycle (one cycle after the valid cycle).
  task automatic fetch(input string tag, input logic [31:0] word, input logic [7:0] exp_pc);
    int n = 0;
    while (bus.instr_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 64'(bus.instr_req), 64'd1);
    check({tag, "_pc"}, 64'(bus.pc), 64'(exp_pc));
    bus.instr_in    = word;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr_in    = '0;
  endtask

  initial begin
    rst             = 1'b0;
    start           = 1'b0;
    bus.instr_in    = '0;
    bus.instr_valid = 1'b0;
    bus.signalBits  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Out of reset, no start: idle indefinitely.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_pc", 64'(bus.pc), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_req", 64'(bus.instr_req), 64'd0);
      check("idle_en", 64'({bus.write, bus.RAMwrite, halted}), 64'd0);
      check("idle_imm", bus.imm_out, 64'd0);
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);

    // ALU: write exactly 3 cycles after valid.
    fetch("alu", enc(OpAlu, 5'd3, 5'd7, 5'd1, 5'd2, 9'd0), 8'd0);
    check("alu_c1_write", 64'(bus.write), 64'd0);
    @(negedge clk);
    check("alu_c2_write", 64'(bus.write), 64'd0);
    check("alu_sel", 64'({bus.readA, bus.readB, bus.functionsel, bus.writeReg}),
          64'({5'd1, 5'd2, 5'd3, 5'd7}));
    check("alu_mux", 64'({bus.muxSelect, bus.wb_sel, bus.ALUcarry}), 64'd0);
    @(negedge clk);
    check("alu_c3_write", 64'(bus.write), 64'd1);
    check("alu_c3_ram", 64'(bus.RAMwrite), 64'd0);
    check("alu_c3_wreg", 64'(bus.writeReg), 64'd7);
    @(negedge clk);
    check("alu_c4_write", 64'(bus.write), 64'd0);

    // ALUI with imm9 = 0x1FF and readB odd (carry-in 1).
    fetch("alui", enc(OpAlui, 5'd0, 5'd3, 5'd4, 5'd5, 9'h1FF), 8'd1);
    @(negedge clk);
    check("alui_mux", 64'(bus.muxSelect), 64'd1);
    check("alui_imm", bus.imm_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("alui_carry", 64'(bus.ALUcarry), 64'd1);
    @(negedge clk);
    check("alui_c3_write", 64'(bus.write), 64'd1);

    // LOAD: write 4 cycles after valid, never RAMwrite.
    fetch("load", enc(OpLoad, 5'd0, 5'd9, 5'd1, 5'd0, 9'd4), 8'd2);
    @(negedge clk);
    check("load_wbsel", 64'(bus.wb_sel), 64'd1);
    check("load_imm", bus.imm_out, 64'd4);
    @(negedge clk);
    check("load_c3", 64'({bus.write, bus.RAMwrite}), 64'd0);
    @(negedge clk);
    check("load_c4", 64'({bus.write, bus.RAMwrite}), 64'b10);
    @(negedge clk);
    check("load_c5", 64'({bus.write, bus.RAMwrite}), 64'd0);

    // STORE: RAMwrite 1-cycle pulse 3 cycles after valid, write stays 0.
    fetch("store", enc(OpStore, 5'd0, 5'd0, 5'd2, 5'd3, 9'd8), 8'd3);
    @(negedge clk);
    check("store_c2", 64'({bus.write, bus.RAMwrite}), 64'd0);
    @(negedge clk);
    check("store_c3", 64'({bus.write, bus.RAMwrite}), 64'b01);
    @(negedge clk);
    check("store_c4", 64'({bus.write, bus.RAMwrite}), 64'd0);

    fetch("nop", enc(OpNop, 5'd0, 5'd0, 5'd0, 5'd0, 9'd0), 8'd4);
    @(negedge clk);
    check("nop_c2", 64'({bus.write, bus.RAMwrite}), 64'd0);

    // Branch taken at pc=5, imm9=-3 -> pc=2.
    bus.signalBits = 4'b0001;
    fetch("br_t", enc(OpBr, 5'b00001, 5'd0, 5'd0, 5'd0, 9'h1FD), 8'd5);
    fetch("jmp3", enc(OpJmp, 5'd0, 5'd0, 5'd0, 5'd0, 9'd3), 8'd2);
    // Branch not taken at pc=5 -> pc=6.
    bus.signalBits = 4'b0000;
    fetch("br_n", enc(OpBr, 5'b00001, 5'd0, 5'd0, 5'd0, 9'h1FD), 8'd5);
    fetch("jmp249", enc(OpJmp, 5'd0, 5'd0, 5'd0, 5'd0, 9'd249), 8'd6);
    // JMP +1 at pc=255 wraps to 0.
    fetch("jmp_wrap", enc(OpJmp, 5'd0, 5'd0, 5'd0, 5'd0, 9'd1), 8'd255);

    // Reset during WB drops the write pulse at once.
    fetch("alu_rst", enc(OpAlu, 5'd3, 5'd7, 5'd1, 5'd2, 9'd5), 8'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_write", 64'(bus.write), 64'd1);
    check("rst_pre_imm", bus.imm_out, 64'd5);
    rst = 1'b0;
    #1;
    check("rst_write", 64'(bus.write), 64'd0);
    check("rst_busy", 64'({busy, bus.instr_req}), 64'd0);
    check("rst_pc", 64'(bus.pc), 64'd0);
    check("rst_sel", 64'({bus.readA, bus.writeReg}), 64'd0);
    check("rst_imm", bus.imm_out, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_idle", 64'({busy, bus.instr_req, bus.write}), 64'd0);

    // HALT, then start resumes at pc+1.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fetch("halt", enc(OpHalt, 5'd0, 5'd0, 5'd0, 5'd0, 9'd0), 8'd0);
    @(negedge clk);
    check("halt_c2_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("halt_flags", 64'({halted, busy, bus.instr_req}), 64'b100);
    repeat (2) @(negedge clk);
    check("halt_hold", 64'(halted), 64'd1);
    check("halt_pc", 64'(bus.pc), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("resume_flags", 64'({halted, busy, bus.instr_req}), 64'b011);
    check("resume_pc", 64'(bus.pc), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
